keypad_debouncer: RTL and testbench
===================================

# keypad_debouncer

Consumes the scanner FSM's held-column and row outputs, debounces a single key press, decodes it to a 4-bit hex key code and emits one `key_valid` pulse per debounced press. Release is debounced as well. It keeps the last two accepted digits for the dual seven-segment display stage downstream.

## Interface
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles required to accept a press or release; 20 ms at 12 MHz; legal range 1 to 2^18-1.
- `CNT_W`, default 18: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clk` in 1: system clock, the only clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `col_q` in 4: one-hot column of the held key from the scanner; 0 when no key is held.
- `row_q` in 4: row lines, already synchronised upstream.
- `key_code` out 4: code of the last accepted key.
- `key_valid` out 1: one-cycle pulse per accepted press.
- `digit_new` out 4: most recent accepted digit.
- `digit_old` out 4: previous accepted digit.

## Operation
- **Decode:** the key is present only if `col_q` and `row_q` are each exactly one-hot. Otherwise there is no key; zero bits or multiple bits both count as no key.
- **Code map (row r, column c):**
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- **States:** IDLE, PRESS_DB, HELD, RELEASE_DB. `cand` (4 bits) holds the candidate code; `cnt` is `CNT_W` bits.
- **IDLE:** when a key is present, load `cand` with its code, clear `cnt`, go to PRESS_DB.
- **PRESS_DB:**
  - Present and code equals `cand`: if `cnt == DEBOUNCE_CYCLES-1`, go to HELD, pulse `key_valid` and shift the digits; otherwise `cnt++`.
  - Absent or a different code: go to IDLE, clear `cnt`, produce no output.
- **HELD:**
  - Code equals `cand`: stay.
  - Absent or a different code: clear `cnt`, go to RELEASE_DB.
  - A second key pressed while HELD is never accepted.
- **RELEASE_DB:**
  - Code equals `cand`: return to HELD, clear `cnt`, no new pulse.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, go to IDLE; else `cnt++`.
- **Digit shift:** happens on the accepting edge only. `digit_old <= digit_new`, `digit_new <= cand`, `key_code <= cand`.
- **Repeats:** pressing the same key twice still shifts, giving equal digits.
- **Counter bounds:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so no wrap.
- **Reset:** asserting `nrst` in any state immediately forces state IDLE, `cnt=0`, `cand=0` and all outputs to 0. This includes reset mid-debounce; a pending press is discarded.
- **Reset values:** `key_code=0`, `key_valid=0`, `digit_new=0`, `digit_old=0`.

## Timing
- All outputs are registered; no combinational path from input to output.
- **Press latency:**
  - Key first sampled present at edge k gives IDLE→PRESS_DB at edge k.
  - `key_valid` is high during the cycle after edge k+`DEBOUNCE_CYCLES`.
  - `key_valid` is high for exactly 1 cycle.
  - `digit_*` and `key_code` update on that same edge.
- **Release:** RELEASE_DB→IDLE needs `DEBOUNCE_CYCLES+1` consecutive sampled-absent cycles, counting the HELD→RELEASE_DB edge.
- **Inputs:** held stable for thousands of cycles by the scanner's slow state rate; this block tolerates any change on any cycle.

## Structure
- **Package `keypad_pkg`:**
  - `kp_state_t` enum, 2 bits.
  - `key_code_t` (`logic [3:0]`).
  - Constant 16-entry map array indexed `{row_idx, col_idx}`.
  - Shared with the display stage.
- **Sub-module `keypad_decode`:** combinational. Inputs `col_q` and `row_q`; outputs `present` and `code`. It contains the one-hot checks, the one-hot-to-index encoders and the map lookup.
- **`keypad_debouncer`:** FSM, counter and output registers only.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Reset:** `nrst=0` asynchronously mid-cycle → all outputs 0 immediately; after release, no pulse with inputs 0.
- **Clean press:** `col_q=0001`, `row_q=0001` from edge k for 12 cycles → `key_valid` high only in the cycle after edge k+4; `key_code=1`, `digit_new=1`, `digit_old=0`.
- **Press bounce:** key present 2 cycles, absent 1, present 5 → no pulse from the first burst; pulse after edge (restart+4) of the final burst.
- **Two keys:** press `col_q=0010`, `row_q=0010` ('5'), release 6 cycles, then press `col_q=1000`, `row_q=1000` ('D') → two pulses; final `digit_old=5`, `digit_new=D`, `key_code=D`.
- **Release bounce:** in HELD, absent 2 cycles then present → no second pulse; absent 6 cycles, then press again → exactly one new pulse.
- **Invalid / reset mid-press:** `row_q=0011` with `col_q=0001` for 10 cycles → no pulse, state IDLE; valid press with `nrst` pulsed low at cycle 2 of PRESS_DB → no pulse, digits stay 0.

Source files
------------

// File: rtl/keypad_debouncer_pkg.sv
// Shared keypad types, code map and one-hot helpers used by the decoder
// and the downstream seven-segment display stage.
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    // Key code indexed by {row_idx, col_idx}.
    localparam key_code_t KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // True when exactly one bit is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Index of the set bit of a one-hot value; 0 for anything else.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debouncer_if.sv
// Scanner-to-debouncer-to-display signal bundle.
interface keypad_debouncer_if;
    import keypad_pkg::*;

    logic [3:0] col_q;
    logic [3:0] row_q;
    key_code_t  key_code;
    logic       key_valid;
    key_code_t  digit_new;
    key_code_t  digit_old;

    // Scanner / environment side.
    modport master (
        output col_q, row_q,
        input  key_code, key_valid, digit_new, digit_old
    );

    // Debouncer side.
    modport slave (
        input  col_q, row_q,
        output key_code, key_valid, digit_new, digit_old
    );

endinterface

// File: rtl/keypad_debouncer_decode.sv
// Combinational keypad decode: validates one-hot column and row and maps
// the pair to a hex key code.
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [3:0] col_q,
    input  logic [3:0] row_q,
    output logic       present,
    output key_code_t  code
);

    logic [1:0] col_idx;
    logic [1:0] row_idx;

    // One-hot checks, index encoders and map lookup.
    always_comb begin
        present = is_onehot4(col_q) && is_onehot4(row_q);
        col_idx = onehot_idx(col_q);
        row_idx = onehot_idx(row_q);
        code    = KEY_MAP[{row_idx, col_idx}];
    end

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces a single keypad press and release, emits one key_valid pulse
// per accepted press and keeps the last two accepted digits.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic                clk,
    input  logic                nrst,
    keypad_debouncer_if.slave   kp
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    kp_state_t        state;
    logic [CNT_W-1:0] cnt;
    key_code_t        cand;
    key_code_t        key_code_r;
    logic             key_valid_r;
    key_code_t        digit_new_r;
    key_code_t        digit_old_r;

    logic             present;
    key_code_t        code;
    logic             same_key;

    keypad_decode u_decode (
        .col_q   (kp.col_q),
        .row_q   (kp.row_q),
        .present (present),
        .code    (code)
    );

    assign same_key = present && (code == cand);

    // Debounce FSM with counter and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            key_code_r  <= '0;
            key_valid_r <= 1'b0;
            digit_new_r <= '0;
            digit_old_r <= '0;
        end else begin
            key_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (present) begin
                        cand  <= code;
                        cnt   <= '0;
                        state <= PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (same_key) begin
                        if (cnt == CNT_LAST) begin
                            state       <= HELD;
                            key_valid_r <= 1'b1;
                            key_code_r  <= cand;
                            digit_new_r <= cand;
                            digit_old_r <= digit_new_r;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                HELD: begin
                    if (!same_key) begin
                        cnt   <= '0;
                        state <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (same_key) begin
                        cnt   <= '0;
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.digit_new = digit_new_r;
    assign kp.digit_old = digit_old_r;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Scoreboard bench for keypad_debouncer with DEBOUNCE_CYCLES=4.
module tb_keypad_debouncer;

    localparam int D = 4;

    typedef struct {
        logic [3:0] code;
        logic [3:0] dnew;
        logic [3:0] dold;
        int         cyc;
    } exp_t;

    logic clk;
    logic nrst;
    int   cyc;
    int   errors;
    int   checks;
    exp_t sb[$];
    logic [3:0] m_new;
    logic [3:0] m_old;

    keypad_debouncer_if kp_if ();

    keypad_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (18)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .kp   (kp_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expect an accepted press of the given code for a key first sampled at
    // the next rising edge.
    task automatic accept(input logic [3:0] code);
        exp_t e;
        m_old = m_new;
        m_new = code;
        e.code = code;
        e.dnew = m_new;
        e.dold = m_old;
        e.cyc  = cyc + 1 + D;
        sb.push_back(e);
    endtask

    task automatic hold(input logic [3:0] c, input logic [3:0] r, input int n);
        kp_if.col_q = c;
        kp_if.row_q = r;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (kp_if.key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("key_code", int'(kp_if.key_code), int'(e.code));
                check("digit_new", int'(kp_if.digit_new), int'(e.dnew));
                check("digit_old", int'(kp_if.digit_old), int'(e.dold));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc    = 0;
        errors = 0;
        checks = 0;
        m_new  = 4'h0;
        m_old  = 4'h0;
        nrst   = 1'b1;
        kp_if.col_q = 4'b0000;
        kp_if.row_q = 4'b0000;

        // Asynchronous reset mid-cycle.
        #3 nrst = 1'b0;
        #1;
        check("rst_key_code", int'(kp_if.key_code), 0);
        check("rst_key_valid", int'(kp_if.key_valid), 0);
        check("rst_digit_new", int'(kp_if.digit_new), 0);
        check("rst_digit_old", int'(kp_if.digit_old), 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        hold(4'b0000, 4'b0000, 3);

        // Clean press of '1'.
        accept(4'h1);
        hold(4'b0001, 4'b0001, 12);
        hold(4'b0000, 4'b0000, 6);

        // Press bounce on '3' (row 0, col 2).
        hold(4'b0100, 4'b0001, 2);
        hold(4'b0000, 4'b0000, 1);
        accept(4'h3);
        hold(4'b0100, 4'b0001, 5);
        hold(4'b0000, 4'b0000, 6);

        // Two keys: '5' then 'D'.
        accept(4'h5);
        hold(4'b0010, 4'b0010, 8);
        hold(4'b0000, 4'b0000, 6);
        accept(4'hD);
        hold(4'b1000, 4'b1000, 8);
        hold(4'b0000, 4'b0000, 6);

        // Release bounce on '8' (row 2, col 1), then repeat press.
        accept(4'h8);
        hold(4'b0010, 4'b0100, 8);
        hold(4'b0000, 4'b0000, 2);
        hold(4'b0010, 4'b0100, 6);
        hold(4'b0000, 4'b0000, 6);
        accept(4'h8);
        hold(4'b0010, 4'b0100, 8);
        hold(4'b0000, 4'b0000, 6);

        // Asynchronous reset with non-zero outputs clears them at once.
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        check("async_key_code", int'(kp_if.key_code), 0);
        check("async_key_valid", int'(kp_if.key_valid), 0);
        check("async_digit_new", int'(kp_if.digit_new), 0);
        check("async_digit_old", int'(kp_if.digit_old), 0);
        @(negedge clk);
        nrst  = 1'b1;
        m_new = 4'h0;
        m_old = 4'h0;
        hold(4'b0000, 4'b0000, 3);

        // Invalid multi-bit row: never a key.
        hold(4'b0001, 4'b0011, 10);
        hold(4'b0000, 4'b0000, 2);

        // Reset during PRESS_DB discards the pending press.
        hold(4'b0001, 4'b0001, 2);
        nrst = 1'b0;
        hold(4'b0001, 4'b0001, 3);
        nrst = 1'b1;
        hold(4'b0000, 4'b0000, 4);
        check("midrst_key_code", int'(kp_if.key_code), 0);
        check("midrst_digit_new", int'(kp_if.digit_new), 0);
        check("midrst_digit_old", int'(kp_if.digit_old), 0);

        // Fresh press of 'E' (row 3, col 0) from IDLE.
        accept(4'hE);
        hold(4'b0001, 4'b1000, 8);
        hold(4'b0000, 4'b0000, 6);

        check("pending_pulses", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
